// File: rtl/bakraid_snd_fifo.sv
// bakraid_snd_fifo: elastic stereo sample FIFO with prefill, underflow hold and sticky error flags
module bakraid_snd_fifo #(
  parameter int DEPTH   = 16,
  parameter int PREFILL = DEPTH / 2
) (
  input  logic                     clk96,
  input  logic                     reset96_n,
  input  logic [15:0]              sample_in_l,
  input  logic [15:0]              sample_in_r,
  input  logic                     sample_in_stb,
  input  logic                     cen_out,
  input  logic                     flush,
  input  logic                     clr_flags,
  output logic [15:0]              sample_out_l,
  output logic [15:0]              sample_out_r,
  output logic                     sample_out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic                     ovf,
  output logic                     unf
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic empty, full, pop, push, ovf_ev, unf_ev;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign level   = count;
  assign playing = state == RUN;
  // state register
  always_ff @(posedge clk96 or negedge reset96_n)
    if (!reset96_n) state <= FILL;
    else state <= state_nx;
  // leave FILL once the prefill level is seen, fall back on underflow; flush always restarts
  always_comb
    state_nx = flush ? FILL :
               state == FILL ? (count >= (AW+1)'(PREFILL) ? RUN : FILL) :
               unf_ev ? FILL : RUN;
  // pop/push qualification; a pop frees room for a push to a full FIFO in the same cycle
  always_comb begin
    pop    = !flush && state == RUN && cen_out && !empty;
    unf_ev = !flush && state == RUN && cen_out && empty;
    push   = !flush && sample_in_stb && (!full || pop);
    ovf_ev = !flush && sample_in_stb && full && !pop;
  end
  // sample storage, no reset needed
  always_ff @(posedge clk96)
    if (push) mem[wr_ptr] <= {sample_in_l, sample_in_r};
  // pointers and occupancy
  always_ff @(posedge clk96 or negedge reset96_n)
    if (!reset96_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // output registers: silence while filling, head on pop, hold on underflow
  always_ff @(posedge clk96 or negedge reset96_n)
    if (!reset96_n) begin
      sample_out_l     <= '0;
      sample_out_r     <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= cen_out && !flush;
      if (cen_out && !flush && state == FILL) {sample_out_l, sample_out_r} <= '0;
      else if (pop) {sample_out_l, sample_out_r} <= mem[rd_ptr];
    end
  // sticky flags; a new event beats a same-cycle clear
  always_ff @(posedge clk96 or negedge reset96_n)
    if (!reset96_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_ev || (ovf && !clr_flags);
      unf <= unf_ev || (unf && !clr_flags);
    end
endmodule

// File: doc/bakraid_snd_fifo.md
# bakraid_snd_fifo

Elastic stereo sample buffer between the YMZ280B sample output and the audio output stage. Samples arrive in the CLK96 domain at the YMZ280B rate (~44.1 kHz, strobes derived from the 16.9344 MHz clock enable). They leave on a separate output-rate clock enable (e.g. 48 kHz) supplied by the clock block. The FIFO absorbs rate mismatch and jitter. It pre-fills before playback, holds the last sample on underflow, drops new samples on overflow, and reports fill level and sticky error flags.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- PREFILL, DEPTH/2, entries required before leaving FILL; 1..DEPTH.

Ports:
- Clock and reset: one clock, CLK96. Reset is asynchronous and active-low, RESET96_N.
- CLK96  in  1  96 MHz system clock; all logic on rising edge.
- RESET96_N  in  1  asynchronous, active-low reset.
- SAMPLE_IN_L  in  16  signed left sample.
- SAMPLE_IN_R  in  16  signed right sample.
- SAMPLE_IN_STB  in  1  one-cycle write strobe; L/R valid in the same cycle.
- CEN_OUT  in  1  one-cycle output-rate enable.
- FLUSH  in  1  synchronous; empties the FIFO and returns to FILL.
- CLR_FLAGS  in  1  synchronous; clears OVF and UNF.
- SAMPLE_OUT_L  out  16  signed left output, registered.
- SAMPLE_OUT_R  out  16  signed right output, registered.
- SAMPLE_OUT_VALID  out  1  one-cycle pulse when SAMPLE_OUT_L/R are updated.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- PLAYING  out  1  high in RUN state.
- OVF  out  1  sticky; a write was dropped because the FIFO was full.
- UNF  out  1  sticky; a read was attempted while the FIFO was empty in RUN.

## Operation
- Storage: DEPTH x 32 bits, holding {L,R}. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register is separate, one bit wider.
- Write: when SAMPLE_IN_STB=1 and the FIFO is not full, or it is full and a pop happens in the same cycle, store the sample and advance the write pointer. Otherwise drop the sample and set OVF.
- State FILL, entered at reset and on FLUSH:
  - Nothing is popped.
  - On each CEN_OUT, output 0/0 and pulse SAMPLE_OUT_VALID.
  - Move to RUN in the cycle after the cycle in which LEVEL >= PREFILL.
- State RUN, on CEN_OUT:
  - FIFO not empty: pop the head into SAMPLE_OUT_L/R.
  - FIFO empty: keep the previous output values, set UNF, and go to FILL.
  - SAMPLE_OUT_VALID pulses in both cases.
- Simultaneous push and pop: count is unchanged. When full, the push is accepted and OVF is not set. When empty in RUN, the pop underflows and the push is stored; there is no bypass.
- FLUSH:
  - Pointers and count go to 0, state goes to FILL.
  - Outputs hold their values.
  - It has priority over any push or pop in the same cycle; that push is discarded and does not set OVF.
- CLR_FLAGS: OVF and UNF go to 0. If an error event occurs in the same cycle, the set wins.
- Reset values: SAMPLE_OUT_L/R=0, SAMPLE_OUT_VALID=0, LEVEL=0, PLAYING=0, OVF=0, UNF=0, state FILL, pointers 0.

## Timing
- Write latency: a sample strobed in cycle t is counted in LEVEL at t+1.
- Read latency: CEN_OUT in cycle t gives updated SAMPLE_OUT_L/R with SAMPLE_OUT_VALID=1 at t+1. The pulse is exactly one cycle wide.
- Back-to-back strobes on consecutive cycles are legal on both sides.
- PLAYING reflects the state register; it changes the cycle after the transition condition.
- OVF and UNF assert the cycle after the offending event.

## Test plan
- Reset mid-stream: assert RESET96_N=0 with LEVEL=5 and OVF=1 -> all outputs 0 immediately, state FILL. After release, the first CEN_OUT gives 0/0 with a valid pulse.
- Prefill (DEPTH=16, PREFILL=8): write 7 samples and pulse CEN_OUT -> output 0/0, LEVEL=7. Write an 8th sample (L=0x1234, R=0xEDCB) -> PLAYING=1. The next CEN_OUT outputs the first written sample and LEVEL=7.
- Overflow: fill with 16 samples, strobe a 17th (0x7FFF/0x8000) -> OVF=1 and LEVEL=16. Then 16 pops return the original 16 samples in order, and 0x7FFF never appears.
- Underflow: in RUN with LEVEL=1, two CEN_OUT pulses -> first outputs the last sample, second repeats it. UNF=1, PLAYING=0.
- Simultaneous events: full FIFO with a same-cycle push and CEN_OUT -> LEVEL stays 16, OVF stays 0. FLUSH with a same-cycle push -> LEVEL=0, state FILL, OVF stays 0.
- Wrap-around: stream 1000 incrementing samples at the same rate as CEN_OUT after prefill -> output sequence is identical and in order, with no OVF or UNF.
